// File: rtl/exec_ctrl_pkg.sv
// Shared types for the execution step controller: FSM state encoding and the
// clock-enable decode used by the top level.
package exec_ctrl_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    HOLD       = 3'd0,
    RUN        = 3'd1,
    STEP_WAIT  = 3'd2,
    STEP_PULSE = 3'd3,
    HALTED     = 3'd4
  } state_t;

  // A breakpoint only blocks free-running; a step always executes one cycle.
  function automatic logic cpu_en_of(input state_t st, input logic bp_hit);
    return ((st == RUN) && !bp_hit) || (st == STEP_PULSE);
  endfunction

endpackage

// File: rtl/step_debouncer.sv
// Synchronizes the raw step button, debounces it, and emits a single-cycle
// pulse each time the accepted level rises.
module step_debouncer #(
  parameter int DEBOUNCE_N = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_async,
  output logic step_pulse
);

  localparam int CW = (DEBOUNCE_N > 2) ? $clog2(DEBOUNCE_N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_N - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          stable_prev_q, stable_prev_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state: the synced level must disagree for DEBOUNCE_N cycles in a row.
  always_comb begin
    sync1_d       = btn_async;
    sync2_d       = sync1_q;
    stable_prev_d = stable_q;
    stable_d      = stable_q;
    cnt_d         = {CW{1'b0}};
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = ~stable_q;
        cnt_d    = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = {CW{1'b0}};
    end
  end

  // State registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cnt_q         <= {CW{1'b0}};
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      cnt_q         <= cnt_d;
    end
  end

  assign step_pulse = stable_q & ~stable_prev_q;

endmodule

// File: rtl/exec_step_controller.sv
// Generates the processor clock-enable for free-run, single-step and halted
// operation, with a PC breakpoint and a count of enabled cycles.
module exec_step_controller
  import exec_ctrl_pkg::*;
#(
  parameter int PC_W       = 32,
  parameter int CNT_W      = 32,
  parameter int DEBOUNCE_N = 16,
  parameter int RST_HOLD   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_select,
  input  logic             clk_step,
  input  logic             resume,
  input  logic             halt_req,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_en,
  output logic             halted,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

  state_t           state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_pulse;
  logic             bp_hit;
  state_t           step_exit;

  step_debouncer #(
    .DEBOUNCE_N(DEBOUNCE_N)
  ) u_step_debouncer (
    .clk        (clk),
    .rst        (rst),
    .btn_async  (clk_step),
    .step_pulse (step_pulse)
  );

  assign bp_hit    = bp_en && (pc == bp_addr);
  assign cpu_en    = cpu_en_of(state_q, bp_hit);
  assign step_exit = clk_select ? STEP_WAIT : RUN;

  // Sequencer next-state; earlier conditions in each state take priority.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, cpu_en};
    case (state_q)
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = step_exit;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RUN: begin
        if (halt_req || bp_hit) begin
          state_d = HALTED;
        end else if (clk_select) begin
          state_d = STEP_WAIT;
        end else begin
          state_d = RUN;
        end
      end
      STEP_WAIT: begin
        if (halt_req) begin
          state_d = HALTED;
        end else if (!clk_select) begin
          state_d = RUN;
        end else if (step_pulse) begin
          state_d = STEP_PULSE;
        end else begin
          state_d = STEP_WAIT;
        end
      end
      // bp_hit is deliberately not looked at here so a step can leave a breakpoint.
      STEP_PULSE: begin
        if (halt_req) begin
          state_d = HALTED;
        end else begin
          state_d = step_exit;
        end
      end
      HALTED: begin
        if (resume || step_pulse) begin
          state_d = STEP_PULSE;
        end else begin
          state_d = HALTED;
        end
      end
      default: begin
        state_d = HOLD;
      end
    endcase
  end

  // State, hold counter and enabled-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HOLD;
      hold_q  <= {HW{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  assign halted      = (state_q == HALTED);
  assign state_o     = state_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_exec_step_controller.sv
// Bench for exec_step_controller: directed scenarios with literal expectations
// plus randomized stimulus, all compared every cycle against a behavioural model.
module tb_exec_step_controller;
  import exec_ctrl_pkg::*;

  localparam int PC_W   = 32;
  localparam int CNT_W  = 32;
  localparam int DEB_N  = 4;
  localparam int HOLD_N = 4;

  logic             clk = 1'b0;
  logic             rst, clk_select, clk_step, resume, halt_req, bp_en;
  logic [PC_W-1:0]  bp_addr, pc;
  logic             cpu_en, halted;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] cycle_count;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  exec_step_controller #(
    .PC_W(PC_W), .CNT_W(CNT_W), .DEBOUNCE_N(DEB_N), .RST_HOLD(HOLD_N)
  ) dut (
    .clk(clk), .rst(rst), .clk_select(clk_select), .clk_step(clk_step),
    .resume(resume), .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr),
    .pc(pc), .cpu_en(cpu_en), .halted(halted), .state_o(state_o),
    .cycle_count(cycle_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  state_t           m_st = HOLD;
  int               m_hold = 0;
  logic [CNT_W-1:0] m_cnt = '0;
  bit               m_acc = 1'b0, m_acc_prev = 1'b0, m_valid = 1'b0;
  bit               btn_hist[$];
  bit               syn_hist[$];

  function automatic bit m_bp();
    return bp_en && (pc == bp_addr);
  endfunction

  function automatic bit m_cpu_en();
    return ((m_st == RUN) && !m_bp()) || (m_st == STEP_PULSE);
  endfunction

  function automatic state_t m_next(input bit pulse);
    state_t leave_to;
    leave_to = clk_select ? STEP_WAIT : RUN;
    case (m_st)
      HOLD:       return (m_hold >= HOLD_N - 1) ? leave_to : HOLD;
      RUN:        return (halt_req || m_bp()) ? HALTED : (clk_select ? STEP_WAIT : RUN);
      STEP_WAIT:  return halt_req ? HALTED : (!clk_select ? RUN : (pulse ? STEP_PULSE : STEP_WAIT));
      STEP_PULSE: return halt_req ? HALTED : leave_to;
      HALTED:     return (resume || pulse) ? STEP_PULSE : HALTED;
      default:    return HOLD;
    endcase
  endfunction

  // Accepted button level flips once the synced level has disagreed for DEB_N edges.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_st = HOLD; m_hold = 0; m_cnt = '0;
      m_acc = 1'b0; m_acc_prev = 1'b0; m_valid = 1'b1;
      btn_hist = '{1'b0, 1'b0};
      syn_hist.delete();
    end else if (m_valid) begin
      bit pulse, flip;
      state_t nx;
      pulse = m_acc && !m_acc_prev;
      nx = m_next(pulse);
      if (m_cpu_en()) m_cnt = m_cnt + 1;
      if (m_st == HOLD) m_hold++;
      m_st = nx;
      syn_hist.push_back(btn_hist[btn_hist.size() - 2]);
      btn_hist.push_back(clk_step);
      flip = (syn_hist.size() >= DEB_N);
      for (int k = 1; k <= DEB_N && flip; k++)
        if (syn_hist[syn_hist.size() - k] == m_acc) flip = 1'b0;
      m_acc_prev = m_acc;
      if (flip) m_acc = !m_acc;
      while (btn_hist.size() > 4) void'(btn_hist.pop_front());
      while (syn_hist.size() > DEB_N) void'(syn_hist.pop_front());
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("model_state",  64'(state_o),     64'(m_st));
      chk("model_halted", 64'(halted),      64'(m_st == HALTED));
      chk("model_cpu_en", 64'(cpu_en),      64'(m_cpu_en()));
      chk("model_count",  64'(cycle_count), 64'(m_cnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after inputs changed past edge P; checks the cycles after P+0..P+11.
  task automatic one_pulse_window(input string name, input int at);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk(name, 64'(cpu_en), 64'(i == at));
    end
  endtask

  logic [CNT_W-1:0] c0;

  initial begin
    rst = 1'b1; clk_select = 1'b0; clk_step = 1'b0; resume = 1'b0;
    halt_req = 1'b0; bp_en = 1'b0; bp_addr = '0; pc = '0;

    // 1. hold then free-run
    step(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_state", 64'(state_o), 64'(HOLD));
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_count", 64'(cycle_count), 64'd0);
    chk("hold_cpu_en", 64'(cpu_en), 64'd0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("hold_cpu_en", 64'(cpu_en), 64'd0);
    end
    @(negedge clk);
    chk("run_cpu_en", 64'(cpu_en), 64'd1);
    chk("run_state", 64'(state_o), 64'(RUN));
    repeat (10) @(negedge clk);
    chk("run_count10", 64'(cycle_count), 64'd10);

    // 2. clean single step
    step(1); clk_select = 1'b1;
    step(3); c0 = m_cnt;
    clk_step = 1'b1;
    one_pulse_window("step_window", 7);
    step(8); clk_step = 1'b0;
    step(10);
    chk("step_count", 64'(cycle_count), 64'(c0 + 1));

    // 3. bouncy press
    c0 = m_cnt;
    for (int b = 0; b < 4; b++) begin
      clk_step = (b % 2 == 0);
      step(2);
    end
    clk_step = 1'b1;
    one_pulse_window("bounce_window", 7);
    step(4); clk_step = 1'b0;
    step(10);
    chk("bounce_count", 64'(cycle_count), 64'(c0 + 1));

    // 4. breakpoint and resume
    clk_select = 1'b0; step(3);
    bp_en = 1'b1; bp_addr = 32'h20; pc = 32'h10;
    step(2); pc = 32'h20;
    @(negedge clk);
    chk("bp_cpu_en", 64'(cpu_en), 64'd0);
    chk("bp_state", 64'(state_o), 64'(RUN));
    @(negedge clk);
    chk("bp_halted", 64'(halted), 64'd1);
    chk("bp_halt_cpu_en", 64'(cpu_en), 64'd0);
    repeat (3) @(negedge clk);
    chk("bp_stays", 64'(halted), 64'd1);
    step(1); resume = 1'b1;
    step(1); resume = 1'b0;
    @(negedge clk);
    chk("resume_cpu_en", 64'(cpu_en), 64'd1);
    chk("resume_state", 64'(state_o), 64'(STEP_PULSE));
    step(1); pc = 32'h24;
    @(negedge clk);
    chk("resume_run", 64'(state_o), 64'(RUN));
    chk("resume_run_en", 64'(cpu_en), 64'd1);
    bp_en = 1'b0;

    // 5. halt beats a simultaneous step
    step(1); clk_select = 1'b1;
    step(3); c0 = m_cnt;
    clk_step = 1'b1;
    step(6); halt_req = 1'b1;
    @(negedge clk);
    chk("prio_wait_en", 64'(cpu_en), 64'd0);
    step(1);
    chk("prio_state", 64'(state_o), 64'(HALTED));
    chk("prio_cpu_en", 64'(cpu_en), 64'd0);
    chk("prio_count", 64'(cycle_count), 64'(c0));
    halt_req = 1'b0; clk_step = 1'b0;
    step(8);
    chk("prio_held", 64'(halted), 64'd1);
    resume = 1'b1; step(1); resume = 1'b0;
    @(negedge clk);
    chk("prio_resume_en", 64'(cpu_en), 64'd1);
    step(1);
    chk("prio_back_wait", 64'(state_o), 64'(STEP_WAIT));

    // 6. reset during STEP_PULSE, button held through reset
    step(2); clk_step = 1'b1;
    step(7); rst = 1'b1;
    @(negedge clk);
    chk("mid_step_en", 64'(cpu_en), 64'd1);
    step(1); rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_state", 64'(state_o), 64'(HOLD));
    chk("mid_rst_cpu_en", 64'(cpu_en), 64'd0);
    chk("mid_rst_count", 64'(cycle_count), 64'd0);
    step(20);
    chk("held_through_rst", 64'(cycle_count), 64'd1);
    clk_step = 1'b0;
    step(10);

    // randomized phase
    for (int c = 0; c < 3000; c++) begin
      step(1);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 63) == 0) clk_select = ~clk_select;
      if ($urandom_range(0, 9) == 0) clk_step = ~clk_step;
      resume = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 24) == 0) halt_req = ~halt_req;
      if ($urandom_range(0, 49) == 0) bp_en = ~bp_en;
      if ($urandom_range(0, 99) == 0) bp_addr = 32'($urandom_range(0, 7) * 4);
      pc = 32'($urandom_range(0, 7) * 4);
    end
    step(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
